// File: rtl/if_id_buffer_pkg.sv
// rtl/if_id_buffer_pkg.sv - shared constants for the fetch/decode buffer
package if_id_buffer_pkg;

    localparam int          DEFAULT_WORD_LEN = 16;
    localparam int          DEFAULT_DEPTH    = 2;
    localparam logic [15:0] NOP_WORD         = 16'h0000;

    // Instruction value presented to decode when no valid pair is at the head
    function automatic logic [DEFAULT_WORD_LEN-1:0] nopInstr();
        return NOP_WORD;
    endfunction

endpackage

// File: rtl/if_id_slot.sv
// rtl/if_id_slot.sv - one {PC, instruction} storage entry with async clear
module if_id_slot
    import if_id_buffer_pkg::*;
#(
    parameter int WORD_LEN = DEFAULT_WORD_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  writeEn,
    input  logic [WORD_LEN-1:0]   pcIn,
    input  logic [WORD_LEN-1:0]   instrIn,
    output logic [WORD_LEN-1:0]   pcOut,
    output logic [WORD_LEN-1:0]   instrOut
);

    // Capture the pair on write enable; reset clears to PC 0 / NOP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcOut    <= '0;
            instrOut <= WORD_LEN'(nopInstr());
        end else if (writeEn) begin
            pcOut    <= pcIn;
            instrOut <= instrIn;
        end
    end

endmodule

// File: rtl/if_id_buffer.sv
// rtl/if_id_buffer.sv - in-order IF/ID decoupling queue with flush
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int WORD_LEN = DEFAULT_WORD_LEN,
    parameter int DEPTH    = DEFAULT_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      if_valid,
    input  logic [WORD_LEN-1:0]       if_pc,
    input  logic [WORD_LEN-1:0]       if_instr,
    output logic                      if_ready,
    output logic                      id_valid,
    output logic [WORD_LEN-1:0]       id_pc,
    output logic [WORD_LEN-1:0]       id_instr,
    input  logic                      id_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]       rdPtr;
    logic [PW-1:0]       wrPtr;
    logic [CW-1:0]       countQ;
    logic                push;
    logic                pop;
    logic [WORD_LEN-1:0] slotPc    [DEPTH];
    logic [WORD_LEN-1:0] slotInstr [DEPTH];

    // Ready depends only on registered occupancy so decode stalls never reach fetch combinationally
    assign if_ready = (countQ != CW'(DEPTH));
    assign id_valid = (countQ != '0);
    assign push     = if_valid & if_ready & ~flush;
    assign pop      = id_valid & id_ready & ~flush;
    assign count    = countQ;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : gSlot
            if_id_slot #(.WORD_LEN(WORD_LEN)) uSlot (
                .clk      (clk),
                .rst      (rst),
                .writeEn  (push && (wrPtr == PW'(g))),
                .pcIn     (if_pc),
                .instrIn  (if_instr),
                .pcOut    (slotPc[g]),
                .instrOut (slotInstr[g])
            );
        end
    endgenerate

    // Head pair is gated so stale slot contents are never visible to decode
    always_comb begin
        id_pc    = '0;
        id_instr = WORD_LEN'(nopInstr());
        if (id_valid) begin
            id_pc    = slotPc[rdPtr];
            id_instr = slotInstr[rdPtr];
        end
    end

    // Pointers wrap naturally at DEPTH; flush wins over any concurrent push or pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr  <= '0;
            wrPtr  <= '0;
            countQ <= '0;
        end else if (flush) begin
            rdPtr  <= '0;
            wrPtr  <= '0;
            countQ <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   countQ <= countQ + 1'b1;
                2'b01:   countQ <= countQ - 1'b1;
                default: countQ <= countQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// tb/tb_if_id_buffer.sv - self-checking bench for if_id_buffer
module tb_if_id_buffer;

    localparam int WL    = 16;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          if_valid;
    logic [WL-1:0] if_pc;
    logic [WL-1:0] if_instr;
    logic          if_ready;
    logic          id_valid;
    logic [WL-1:0] id_pc;
    logic [WL-1:0] id_instr;
    logic          id_ready;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    if_id_buffer #(.WORD_LEN(WL), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_instr (id_instr),
        .id_ready (id_ready),
        .count    (count)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
    } pair_t;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [15:0] pc;
        logic [15:0] ins;
        logic        ir;
        int          expCnt;
    } vec_t;

    pair_t sb[$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, compare outputs against the scoreboard head, clock, compare count
    task automatic step(input logic fl, input logic iv, input logic [15:0] pc, input logic [15:0] ins,
                        input logic ir, input int expCnt, input string tag);
        pair_t head;
        logic  mPush;
        logic  mPop;
        @(negedge clk);
        flush    = fl;
        if_valid = iv;
        if_pc    = pc;
        if_instr = ins;
        id_ready = ir;
        #1;
        chk($sformatf("%s.if_ready", tag), {31'b0, if_ready}, {31'b0, (sb.size() < DEPTH)});
        chk($sformatf("%s.id_valid", tag), {31'b0, id_valid}, {31'b0, (sb.size() != 0)});
        if (sb.size() != 0) begin
            chk($sformatf("%s.id_pc", tag), {16'b0, id_pc}, {16'b0, sb[0].pc});
            chk($sformatf("%s.id_instr", tag), {16'b0, id_instr}, {16'b0, sb[0].instr});
        end else begin
            chk($sformatf("%s.id_pc_gated", tag), {16'b0, id_pc}, 32'h0);
            chk($sformatf("%s.id_instr_gated", tag), {16'b0, id_instr}, 32'h0);
        end
        mPush = iv && (sb.size() < DEPTH) && !fl;
        mPop  = (sb.size() != 0) && ir && !fl;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
        end else begin
            if (mPop) head = sb.pop_front();
            if (mPush) sb.push_back('{pc: pc, instr: ins});
        end
        chk($sformatf("%s.count_model", tag), {30'b0, count}, sb.size());
        if (expCnt >= 0) chk($sformatf("%s.count_table", tag), {30'b0, count}, expCnt);
    endtask

    vec_t vecs[15];

    initial begin
        vecs = '{
            '{1'b0, 1'b1, 16'h0004, 16'h1234, 1'b1, 1},
            '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0},
            '{1'b0, 1'b1, 16'h0000, 16'hA000, 1'b0, 1},
            '{1'b0, 1'b1, 16'h0004, 16'hA004, 1'b0, 2},
            '{1'b0, 1'b1, 16'h0008, 16'hA008, 1'b0, 2},
            '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1},
            '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0},
            '{1'b0, 1'b1, 16'h0010, 16'hB010, 1'b0, 1},
            '{1'b0, 1'b1, 16'h0014, 16'hB014, 1'b0, 2},
            '{1'b1, 1'b1, 16'h0018, 16'hB018, 1'b1, 0},
            '{1'b0, 1'b1, 16'h0040, 16'hC040, 1'b0, 1},
            '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0},
            '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 0},
            '{1'b0, 1'b1, 16'h0050, 16'hD050, 1'b0, 1},
            '{1'b1, 1'b1, 16'h0054, 16'hD054, 1'b1, 0}
        };

        rst      = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_pc    = '0;
        if_instr = '0;
        id_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.id_valid", {31'b0, id_valid}, 32'h0);
        chk("reset.id_pc", {16'b0, id_pc}, 32'h0);
        chk("reset.id_instr", {16'b0, id_instr}, 32'h0);
        chk("reset.if_ready", {31'b0, if_ready}, 32'h1);
        chk("reset.count", {30'b0, count}, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ins, vecs[i].ir, vecs[i].expCnt,
                 $sformatf("vec%0d", i));
        end

        // Streaming: one push and one pop per cycle, pointers wrap repeatedly
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 16'(4 * k), 16'(16'h5000 + k), 1'b1, 1, $sformatf("stream%0d", k));
        end
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, "stream_drain");

        // Hold: full buffer, decode stalled, head must stay put
        step(1'b0, 1'b1, 16'h0060, 16'hE060, 1'b0, 1, "hold_fill0");
        step(1'b0, 1'b1, 16'h0064, 16'hE064, 1'b0, 2, "hold_fill1");
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 16'h0068, 16'hE068, 1'b0, 2, $sformatf("hold%0d", k));
        end

        // Reset mid-run with two entries queued
        @(negedge clk);
        if_valid = 1'b0;
        id_ready = 1'b0;
        flush    = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midreset.id_valid", {31'b0, id_valid}, 32'h0);
        chk("midreset.id_instr", {16'b0, id_instr}, 32'h0);
        chk("midreset.count", {30'b0, count}, 32'h0);
        chk("midreset.if_ready", {31'b0, if_ready}, 32'h1);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b1, 16'h0070, 16'hF070, 1'b1, 1, "post_reset_push");
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, "post_reset_pop");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
